// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
//
// Registered 1-to-N stream demultiplexer with valid/ready flow control.
// Each accepted input word goes to one channel (unicast, chosen by in_sel) or to
// every channel at once (broadcast). Every channel owns a one-entry output
// register, so routing adds one cycle of latency and keeps full throughput.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : asynchronous active-high reset
//   in_data    : input word
//   in_valid   : in_data / in_sel / in_bcast are valid
//   in_ready   : block accepts the input this cycle (combinational)
//   in_sel     : unicast destination channel index
//   in_bcast   : 1 = deliver to every channel, in_sel ignored
//   out_data   : channel i data at [i*WIDTH +: WIDTH]
//   out_valid  : per-channel valid
//   out_ready  : per-channel consumer ready
//   drop       : one-cycle pulse per word discarded for an out-of-range in_sel
//   drop_count : saturating (255) count of dropped words
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holding valid must keep its payload stable until the
// transfer; in_ready never looks at in_valid, and each channel holds
// out_data/out_valid stable while out_valid && !out_ready.
// -----------------------------------------------------------------------------
module stream_demux #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 8,
  parameter int SEL_WIDTH = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_WIDTH-1:0]      in_sel,
  input  logic                      in_bcast,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic                      drop,
  output logic [7:0]                drop_count
);

  // Channel storage; packed so element i lands on bits [i*WIDTH +: WIDTH].
  logic [CHANNELS-1:0][WIDTH-1:0] data_q, data_d;
  logic [CHANNELS-1:0]            valid_q, valid_d;
  logic                           drop_q, drop_d;
  logic [7:0]                     drop_count_q, drop_count_d;

  logic [CHANNELS-1:0] can_accept;
  logic [CHANNELS-1:0] sel_hit;
  logic [CHANNELS-1:0] load;
  logic                in_range;
  logic                accept;

  // Routing and flow control. sel_hit is a one-hot decode of in_sel; it is
  // all-zero when in_sel points past the last channel, which doubles as the
  // out-of-range detector and avoids indexing beyond the channel array.
  always_comb begin
    can_accept = '0;
    sel_hit    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      can_accept[i] = !valid_q[i] || out_ready[i];
      sel_hit[i]    = (in_sel == SEL_WIDTH'(i));
    end
    in_range = |sel_hit;

    if (in_bcast) begin
      in_ready = &can_accept;
    end else if (in_range) begin
      in_ready = |(sel_hit & can_accept);
    end else begin
      // Out-of-range words are swallowed so the producer never deadlocks.
      in_ready = 1'b1;
    end

    accept = in_valid && in_ready;
  end

  // Next-state for channel registers and drop statistics.
  always_comb begin
    load    = '0;
    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 0; i < CHANNELS; i++) begin
      load[i] = accept && (in_bcast || sel_hit[i]);
      // A load wins over a consume in the same cycle: new word replaces old.
      valid_d[i] = load[i] || (valid_q[i] && !out_ready[i]);
      if (load[i]) begin
        data_d[i] = in_data;
      end
    end

    drop_d       = accept && !in_bcast && !in_range;
    drop_count_d = drop_count_q;
    if (drop_d && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q       <= '0;
      valid_q      <= '0;
      drop_q       <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      data_q       <= data_d;
      valid_q      <= valid_d;
      drop_q       <= drop_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign drop       = drop_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_stream_demux.sv
// -----------------------------------------------------------------------------
// tb_stream_demux
//
// Directed bench for stream_demux. An 8-channel instance covers unicast,
// stalls, broadcast gating, streaming and asynchronous reset; a 6-channel
// instance (SEL_WIDTH=3) covers out-of-range drops and drop_count saturation.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_stream_demux;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- 8-channel DUT ----------------
  logic [7:0]  in_data8;
  logic        in_valid8;
  logic        in_ready8;
  logic [2:0]  in_sel8;
  logic        in_bcast8;
  logic [63:0] out_data8;
  logic [7:0]  out_valid8;
  logic [7:0]  out_ready8;
  logic        drop8;
  logic [7:0]  drop_count8;

  stream_demux #(.WIDTH(8), .CHANNELS(8), .SEL_WIDTH(3)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data8),
    .in_valid   (in_valid8),
    .in_ready   (in_ready8),
    .in_sel     (in_sel8),
    .in_bcast   (in_bcast8),
    .out_data   (out_data8),
    .out_valid  (out_valid8),
    .out_ready  (out_ready8),
    .drop       (drop8),
    .drop_count (drop_count8)
  );

  // ---------------- 6-channel DUT ----------------
  logic [7:0]  in_data6;
  logic        in_valid6;
  logic        in_ready6;
  logic [2:0]  in_sel6;
  logic        in_bcast6;
  logic [47:0] out_data6;
  logic [5:0]  out_valid6;
  logic [5:0]  out_ready6;
  logic        drop6;
  logic [7:0]  drop_count6;

  stream_demux #(.WIDTH(8), .CHANNELS(6), .SEL_WIDTH(3)) dut6 (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data6),
    .in_valid   (in_valid6),
    .in_ready   (in_ready6),
    .in_sel     (in_sel6),
    .in_bcast   (in_bcast6),
    .out_data   (out_data6),
    .out_valid  (out_valid6),
    .out_ready  (out_ready6),
    .drop       (drop6),
    .drop_count (drop_count6)
  );

  // ---------------- checking ----------------
  int chk_cnt;
  int pass_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       vld;
    logic [2:0] sel;
    logic       bc;
    logic [7:0] dat;
    logic [7:0] ordy;
    logic       exp_rdy;
    logic [7:0] exp_ov;
    logic       chk;
    logic [2:0] ch;
    logic [7:0] exp_d;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs[NVEC];

  // Drive one vector, check at the falling edge, advance past the next edge.
  task automatic apply_vec(input vec_t v, input int idx);
    in_valid8  = v.vld;
    in_sel8    = v.sel;
    in_bcast8  = v.bc;
    in_data8   = v.dat;
    out_ready8 = v.ordy;
    @(negedge clk);
    check($sformatf("vec%0d_in_ready", idx), 64'(in_ready8), 64'(v.exp_rdy));
    check($sformatf("vec%0d_out_valid", idx), 64'(out_valid8), 64'(v.exp_ov));
    check($sformatf("vec%0d_drop", idx), 64'(drop8), 64'(1'b0));
    if (v.chk) begin
      check($sformatf("vec%0d_ch%0d_data", idx, v.ch),
            64'(out_data8[int'(v.ch)*8 +: 8]), 64'(v.exp_d));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle8();
    in_valid8 = 1'b0;
    in_sel8   = 3'd0;
    in_bcast8 = 1'b0;
    in_data8  = 8'h00;
  endtask

  // Scoreboard for the channel-5 stream.
  logic [7:0] exp_q[$];
  int         delivered;

  task automatic sb_pop5();
    logic [7:0] e;
    if (out_valid8[5] && out_ready8[5]) begin
      if (exp_q.size() == 0) begin
        check("stream_extra_word", 64'(out_data8[47:40]), 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("stream_data", 64'(out_data8[47:40]), 64'(e));
        delivered++;
      end
    end
  endtask

  initial begin
    chk_cnt   = 0;
    pass_cnt  = 0;
    delivered = 0;

    // Vectors: expected outputs reflect state left by the previous edges.
    //           vld   sel   bc    dat    ordy   rdy   ov     chk   ch    data
    vecs[0]  = '{1'b1, 3'd3, 1'b0, 8'hA5, 8'hFF, 1'b1, 8'h00, 1'b1, 3'd3, 8'h00};
    vecs[1]  = '{1'b0, 3'd3, 1'b0, 8'h00, 8'hFF, 1'b1, 8'h08, 1'b1, 3'd3, 8'hA5};
    vecs[2]  = '{1'b0, 3'd3, 1'b0, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd3, 8'h00};
    vecs[3]  = '{1'b1, 3'd2, 1'b0, 8'h22, 8'h00, 1'b1, 8'h00, 1'b0, 3'd2, 8'h00};
    vecs[4]  = '{1'b1, 3'd2, 1'b0, 8'h23, 8'h00, 1'b0, 8'h04, 1'b1, 3'd2, 8'h22};
    vecs[5]  = '{1'b1, 3'd6, 1'b0, 8'h66, 8'h00, 1'b1, 8'h04, 1'b1, 3'd2, 8'h22};
    vecs[6]  = '{1'b1, 3'd2, 1'b0, 8'h23, 8'h00, 1'b0, 8'h44, 1'b1, 3'd6, 8'h66};
    vecs[7]  = '{1'b1, 3'd2, 1'b0, 8'h23, 8'h04, 1'b1, 8'h44, 1'b1, 3'd2, 8'h22};
    vecs[8]  = '{1'b0, 3'd2, 1'b0, 8'h00, 8'h00, 1'b0, 8'h44, 1'b1, 3'd2, 8'h23};
    vecs[9]  = '{1'b1, 3'd7, 1'b0, 8'h77, 8'h44, 1'b1, 8'h44, 1'b1, 3'd6, 8'h66};
    vecs[10] = '{1'b1, 3'd0, 1'b1, 8'h3C, 8'h7F, 1'b0, 8'h80, 1'b1, 3'd7, 8'h77};
    vecs[11] = '{1'b1, 3'd0, 1'b1, 8'h3C, 8'h7F, 1'b0, 8'h80, 1'b1, 3'd0, 8'h00};
    vecs[12] = '{1'b1, 3'd0, 1'b1, 8'h3C, 8'hFF, 1'b1, 8'h80, 1'b1, 3'd7, 8'h77};
    vecs[13] = '{1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b1, 3'd0, 8'h3C};
    vecs[14] = '{1'b0, 3'd5, 1'b0, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b1, 3'd5, 8'h3C};
    vecs[15] = '{1'b0, 3'd5, 1'b0, 8'h00, 8'hFF, 1'b1, 8'hFF, 1'b1, 3'd7, 8'h3C};
    vecs[16] = '{1'b0, 3'd5, 1'b0, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00};

    idle8();
    out_ready8 = 8'hFF;
    in_valid6  = 1'b0;
    in_sel6    = 3'd0;
    in_bcast6  = 1'b0;
    in_data6   = 8'h00;
    out_ready6 = 6'h3F;

    // ---------------- reset ----------------
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid8", 64'(out_valid8), 64'h0);
    check("rst_out_data8", out_data8, 64'h0);
    check("rst_drop8", 64'(drop8), 64'h0);
    check("rst_drop_count8", 64'(drop_count8), 64'h0);
    check("rst_out_valid6", 64'(out_valid6), 64'h0);
    check("rst_drop_count6", 64'(drop_count6), 64'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < NVEC; i++) begin
      apply_vec(vecs[i], i);
    end

    // ---------------- stream 0x01..0x10 to channel 5 ----------------
    out_ready8 = 8'hFF;
    for (int w = 1; w <= 16; w++) begin
      in_valid8 = 1'b1;
      in_sel8   = 3'd5;
      in_bcast8 = 1'b0;
      in_data8  = 8'(w);
      @(negedge clk);
      check("stream_in_ready", 64'(in_ready8), 64'h1);
      check("stream_out_valid", 64'(out_valid8), (w == 1) ? 64'h00 : 64'h20);
      if (in_ready8) exp_q.push_back(8'(w));
      sb_pop5();
      @(posedge clk);
      #1;
    end
    idle8();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      sb_pop5();
      @(posedge clk);
      #1;
    end
    check("stream_delivered", 64'(delivered), 64'd16);
    check("stream_queue_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("stream_drained", 64'(out_valid8), 64'h0);
    @(posedge clk);
    #1;

    // ---------------- out-of-range drops on the 6-channel instance ----------------
    for (int n = 0; n < 302; n++) begin
      in_valid6 = 1'b1;
      in_bcast6 = 1'b0;
      in_sel6   = (n == 1) ? 3'd7 : ((n % 2 == 1) ? 3'd7 : 3'd6);
      in_data6  = 8'(n);
      @(negedge clk);
      check($sformatf("drop%0d_in_ready", n), 64'(in_ready6), 64'h1);
      check($sformatf("drop%0d_out_valid", n), 64'(out_valid6), 64'h0);
      check($sformatf("drop%0d_pulse", n), 64'(drop6), (n > 0) ? 64'h1 : 64'h0);
      check($sformatf("drop%0d_count", n), 64'(drop_count6), (n > 255) ? 64'd255 : 64'(n));
      @(posedge clk);
      #1;
    end
    in_valid6 = 1'b0;
    @(negedge clk);
    check("drop_last_pulse", 64'(drop6), 64'h1);
    check("drop_count_sat", 64'(drop_count6), 64'd255);
    @(posedge clk);
    #1;
    in_valid6 = 1'b1;
    in_sel6   = 3'd5;
    in_data6  = 8'h5E;
    @(negedge clk);
    check("drop_end_pulse", 64'(drop6), 64'h0);
    check("c6_inrange_ready", 64'(in_ready6), 64'h1);
    @(posedge clk);
    #1;
    in_valid6 = 1'b0;
    @(negedge clk);
    check("c6_inrange_valid", 64'(out_valid6), 64'h20);
    check("c6_inrange_data", 64'(out_data6[47:40]), 64'h5E);
    check("c6_inrange_nodrop", 64'(drop6), 64'h0);
    check("c6_count_held", 64'(drop_count6), 64'd255);
    @(posedge clk);
    #1;

    // ---------------- asynchronous reset mid-stream ----------------
    out_ready8 = 8'h00;
    in_valid8  = 1'b1;
    in_sel8 = 3'd1; in_data8 = 8'h11;
    @(posedge clk); #1;
    in_sel8 = 3'd4; in_data8 = 8'h44;
    @(posedge clk); #1;
    in_sel8 = 3'd6; in_data8 = 8'h66;
    @(posedge clk); #1;
    in_sel8 = 3'd3; in_data8 = 8'hEE;
    @(negedge clk);
    check("pre_rst_valid", 64'(out_valid8), 64'h52);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid8", 64'(out_valid8), 64'h0);
    check("async_rst_data8", out_data8, 64'h0);
    check("async_rst_valid6", 64'(out_valid6), 64'h0);
    check("async_rst_count6", 64'(drop_count6), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle8();
    out_ready8 = 8'hFF;
    @(negedge clk);
    check("post_rst_no_replay", 64'(out_valid8), 64'h0);
    @(posedge clk);
    #1;
    in_valid8 = 1'b1;
    in_sel8   = 3'd0;
    in_data8  = 8'h5A;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready8), 64'h1);
    @(posedge clk);
    #1;
    idle8();
    @(negedge clk);
    check("post_rst_valid", 64'(out_valid8), 64'h01);
    check("post_rst_data", 64'(out_data8[7:0]), 64'h5A);
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
